// File: rtl/datamem_lsu.sv
// RV32I load/store unit: byte-lane RAM with wait states, sign/zero extension,
// misalignment rejection and one memory-mapped GPIO output register.
module datamem_lsu #(
  parameter int unsigned           ADDR_WIDTH  = 12,
  parameter int unsigned           WAIT_STATES = 0,
  parameter int unsigned           GPIO_WIDTH  = 8,
  parameter logic [ADDR_WIDTH-1:0] GPIO_ADDR   = 12'hFFC
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req,
  input  logic                  i_we,
  input  logic [2:0]            i_funct3,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [31:0]           i_wdata,
  output logic                  o_busy,
  output logic                  o_rvalid,
  output logic [31:0]           o_rdata,
  output logic                  o_misalign,
  output logic [GPIO_WIDTH-1:0] o_gpio
);
  localparam int unsigned DEPTH = 2 ** (ADDR_WIDTH - 2);
  localparam logic [3:0]  WS_M1 = 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  state_t                  r_state, w_next;
  logic                    r_we;
  logic [2:0]              r_funct3;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [31:0]             r_wdata;
  logic [3:0]              r_cnt;
  logic                    r_misalign;
  logic [GPIO_WIDTH-1:0]   r_gpio;
  logic [31:0]             r_rdword;
  logic [31:0]             r_mem [DEPTH];

  logic                    w_illegal, w_accept, w_hit;
  logic [ADDR_WIDTH-3:0]   w_idx;
  logic [3:0]              w_be;
  logic [31:0]             w_wlanes, w_bmask, w_gpio32, w_gpio_upd, w_ext;
  logic [7:0]              w_byte;
  logic [15:0]             w_half;

  always_comb begin
    w_illegal = 1'b0;
    case (i_funct3)
      3'b000, 3'b100: w_illegal = 1'b0;
      3'b001, 3'b101: w_illegal = i_addr[0];
      3'b010:         w_illegal = (i_addr[1:0] != 2'b00);
      default:        w_illegal = 1'b1;
    endcase
    if (i_we && i_funct3[2]) w_illegal = 1'b1;
  end

  assign w_accept = (r_state == S_IDLE) && i_req && !w_illegal;
  assign w_idx    = r_addr[ADDR_WIDTH-1:2];
  assign w_hit    = (r_addr[ADDR_WIDTH-1:2] == GPIO_ADDR[ADDR_WIDTH-1:2]);

  always_comb begin
    w_be     = 4'b1111;
    w_wlanes = r_wdata;
    case (r_funct3[1:0])
      2'b00: begin
        w_be     = 4'b0001 << r_addr[1:0];
        w_wlanes = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be     = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wlanes = {2{r_wdata[15:0]}};
      end
      default: ;
    endcase
    w_bmask = {{8{w_be[3]}}, {8{w_be[2]}}, {8{w_be[1]}}, {8{w_be[0]}}};
  end

  // GPIO is handled as a zero-padded 32-bit word so stores and loads share the lane logic
  always_comb begin
    w_gpio32                   = '0;
    w_gpio32[GPIO_WIDTH-1:0]   = r_gpio;
    w_gpio_upd                 = (w_gpio32 & ~w_bmask) | (w_wlanes & w_bmask);
  end

  always_comb begin
    case (r_addr[1:0])
      2'b00:   w_byte = r_rdword[7:0];
      2'b01:   w_byte = r_rdword[15:8];
      2'b10:   w_byte = r_rdword[23:16];
      default: w_byte = r_rdword[31:24];
    endcase
    w_half = r_addr[1] ? r_rdword[31:16] : r_rdword[15:0];
    case (r_funct3)
      3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_ext = {24'h0, w_byte};
      3'b001:  w_ext = {{16{w_half[15]}}, w_half};
      3'b101:  w_ext = {16'h0, w_half};
      default: w_ext = r_rdword;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
      S_WAIT:   if (r_cnt == '0) w_next = S_ACCESS;
      S_ACCESS: w_next = r_we ? S_IDLE : S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_we       <= 1'b0;
      r_funct3   <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_cnt      <= '0;
      r_misalign <= 1'b0;
      r_gpio     <= '0;
      r_rdword   <= '0;
    end else begin
      r_misalign <= (r_state == S_IDLE) && i_req && w_illegal;
      if (w_accept) begin
        r_we     <= i_we;
        r_funct3 <= i_funct3;
        r_addr   <= i_addr;
        r_wdata  <= i_wdata;
        r_cnt    <= WS_M1;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (r_state == S_ACCESS) begin
        if (r_we) begin
          if (w_hit) r_gpio <= w_gpio_upd[GPIO_WIDTH-1:0];
        end else begin
          r_rdword <= w_hit ? w_gpio32 : r_mem[w_idx];
        end
      end
    end
  end

  // RAM has no reset; the reset term only suppresses a store caught at the reset edge
  always_ff @(posedge i_clk) begin
    if (i_rst_n && (r_state == S_ACCESS) && r_we && !w_hit) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][b*8 +: 8] <= w_wlanes[b*8 +: 8];
      end
    end
  end

  assign o_busy     = (r_state != S_IDLE);
  assign o_rvalid   = (r_state == S_RESP);
  assign o_rdata    = (r_state == S_RESP) ? w_ext : '0;
  assign o_misalign = r_misalign;
  assign o_gpio     = r_gpio;

endmodule
